// File: rtl/z16_pkg.sv
// Shared types, constants and small helpers for the Z16 instruction fetch stage.
package z16_pkg;

    typedef logic [15:0] z16_word_t;
    typedef logic [15:0] z16_addr_t;

    localparam int Z16_INSTR_BYTES = 2;

    typedef enum logic {
        FS_BOOT  = 1'b0,
        FS_FETCH = 1'b1
    } z16_fetch_state_t;

    // Instructions are halfword aligned, so the low address bit is always dropped.
    function automatic z16_addr_t z16_align(input z16_addr_t addr);
        return {addr[15:1], 1'b0};
    endfunction

    function automatic logic [15:0] z16_sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/z16_fetch_chk.sv
// Runtime invariants of the fetch stage: bus response accounting and buffer credit.
module z16_fetch_chk #(
    parameter int OCNT_W = 2,
    parameter int FCNT_W = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    input logic              rvalid_i,
    input logic              keep_i,
    input logic              pop_i,
    input logic              issue_i,
    input logic              ififo_full_i,
    input logic              tagq_full_i,
    input logic              tagq_empty_i,
    input logic [OCNT_W-1:0] outstanding_i,
    input logic [OCNT_W-1:0] discard_i,
    input logic [FCNT_W-1:0] tagq_count_i
);

    a_rvalid_has_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_i |-> (outstanding_i != '0));

    a_no_ififo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (keep_i && ififo_full_i) |-> pop_i);

    a_tag_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
        issue_i |-> !tagq_full_i);

    a_tag_present: assert property (@(posedge clk_i) disable iff (!rst_ni)
        keep_i |-> !tagq_empty_i);

    // Every live tag plus every response still to be dropped accounts for one outstanding read.
    a_tag_balance: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (32'(tagq_count_i) + 32'(discard_i)) == 32'(outstanding_i));

    a_discard_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        discard_i <= outstanding_i);

endmodule

// File: rtl/z16_fetch_fifo.sv
// Small synchronous FIFO with flush; used for both the instruction buffer and the PC tag queue.
module z16_fetch_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 fetch stage: PC, imem req/gnt/rvalid issue, tagged instruction buffer, redirect flush.
// Define Z16_FETCH_PERF_EN to add the o_perf_fetched / o_perf_bubble saturating counters.
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter int        FIFO_DEPTH      = 2,
    parameter int        MAX_OUTSTANDING = 2,
    parameter z16_addr_t RESET_PC        = 16'h0000
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_redirect,
    input  z16_addr_t i_redirect_pc,
    output logic      o_imem_req,
    output z16_addr_t o_imem_addr,
    input  logic      i_imem_gnt,
    input  logic      i_imem_rvalid,
    input  z16_word_t i_imem_rdata,
    output z16_word_t o_instr,
    output z16_addr_t o_instr_pc,
    output logic      o_instr_valid,
    input  logic      i_instr_ready
`ifdef Z16_FETCH_PERF_EN
    ,
    output logic [15:0] o_perf_fetched,
    output logic [15:0] o_perf_bubble
`endif
);

    localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    z16_fetch_state_t  state_q, state_d;
    z16_addr_t         pc_q, pc_d;
    logic [OCNT_W-1:0] outstanding_q, outstanding_d;
    logic [OCNT_W-1:0] discard_q, discard_d;

    logic              fetch_s, req_s, issue_s, drop_s, keep_s, pop_s;
    logic [FCNT_W-1:0] ififo_count_s, tagq_count_s;
    logic              ififo_full_s, ififo_empty_s, tagq_full_s, tagq_empty_s;
    logic [31:0]       ififo_head_s;
    z16_addr_t         tag_head_s;

    assign fetch_s = (state_q == FS_FETCH);
    // Credit counts in-flight reads against free buffer space; ready is deliberately not used.
    assign req_s   = fetch_s && !i_redirect
                     && ((32'(ififo_count_s) + 32'(outstanding_q)) < 32'(FIFO_DEPTH))
                     && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
    assign issue_s = req_s && i_imem_gnt;
    assign drop_s  = i_imem_rvalid && (discard_q != '0);
    assign keep_s  = i_imem_rvalid && (discard_q == '0) && !i_redirect;
    assign pop_s   = !ififo_empty_s && i_instr_ready && !i_redirect;

    assign o_imem_req    = req_s;
    assign o_imem_addr   = req_s ? pc_q : 16'h0000;
    assign o_instr_valid = !ififo_empty_s;
    assign o_instr       = ififo_empty_s ? 16'h0000 : ififo_head_s[31:16];
    assign o_instr_pc    = ififo_empty_s ? 16'h0000 : ififo_head_s[15:0];

    // State, PC and read-accounting next-state; a redirect converts all in-flight reads to drops.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + OCNT_W'(issue_s) - OCNT_W'(i_imem_rvalid);
        discard_d     = discard_q;
        case (state_q)
            FS_BOOT:  state_d = FS_FETCH;
            FS_FETCH: state_d = FS_FETCH;
            default:  state_d = FS_BOOT;
        endcase
        if (i_redirect) begin
            pc_d      = z16_align(i_redirect_pc);
            discard_d = outstanding_q - OCNT_W'(i_imem_rvalid);
        end else begin
            if (issue_s) begin
                pc_d = pc_q + z16_addr_t'(Z16_INSTR_BYTES);
            end else begin
                pc_d = pc_q;
            end
            discard_d = discard_q - OCNT_W'(drop_s);
        end
    end

    // Fetch control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= FS_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    z16_fetch_fifo #(.DATA_W(32), .DEPTH(FIFO_DEPTH)) u_ififo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (keep_s),
        .pop_i   (pop_s),
        .flush_i (i_redirect),
        .data_i  ({i_imem_rdata, tag_head_s}),
        .data_o  (ififo_head_s),
        .count_o (ififo_count_s),
        .full_o  (ififo_full_s),
        .empty_o (ififo_empty_s)
    );

    z16_fetch_fifo #(.DATA_W(16), .DEPTH(FIFO_DEPTH)) u_tagq (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (issue_s),
        .pop_i   (keep_s),
        .flush_i (i_redirect),
        .data_i  (pc_q),
        .data_o  (tag_head_s),
        .count_o (tagq_count_s),
        .full_o  (tagq_full_s),
        .empty_o (tagq_empty_s)
    );

    z16_fetch_chk #(.OCNT_W(OCNT_W), .FCNT_W(FCNT_W)) u_chk (
        .clk_i         (i_clk),
        .rst_ni        (i_rst_n),
        .rvalid_i      (i_imem_rvalid),
        .keep_i        (keep_s),
        .pop_i         (pop_s),
        .issue_i       (issue_s),
        .ififo_full_i  (ififo_full_s),
        .tagq_full_i   (tagq_full_s),
        .tagq_empty_i  (tagq_empty_s),
        .outstanding_i (outstanding_q),
        .discard_i     (discard_q),
        .tagq_count_i  (tagq_count_s)
    );

`ifdef Z16_FETCH_PERF_EN
    logic [15:0] perf_fetched_q;
    logic [15:0] perf_bubble_q;

    // Event counters survive redirects and clear only on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_fetched_q <= 16'h0000;
            perf_bubble_q  <= 16'h0000;
        end else begin
            if (keep_s) begin
                perf_fetched_q <= z16_sat_inc(perf_fetched_q);
            end
            if (fetch_s && ififo_empty_s) begin
                perf_bubble_q <= z16_sat_inc(perf_bubble_q);
            end
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Scoreboard bench for z16_fetch_unit: a PC model predicts each issued address and the
// word the decoder must later see; a latency-programmable memory model answers requests.
module tb_z16_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        req;
    logic [15:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        valid;
    logic        ready;
`ifdef Z16_FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_bubble;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int first_valid = -1;
    int rv_cnt = 0;
    int found;
    int exp_disc;
    logic [15:0] model_pc;
    logic [15:0] snap_pc;
    logic [15:0] exp_q[$];
    logic [15:0] pend_addr[$];
    int          pend_due[$];

    always #5 clk = ~clk;

    z16_fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (valid),
        .i_instr_ready (ready)
`ifdef Z16_FETCH_PERF_EN
        ,
        .o_perf_fetched(perf_fetched),
        .o_perf_bubble (perf_bubble)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Called at the falling edge: memory drives its response, then outputs settle.
    task automatic pre();
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend_addr.pop_front());
            pend_due.delete(0);
            rv_cnt++;
        end else begin
            rvalid = 1'b0;
            rdata  = 16'h0000;
        end
        #1;
    endtask

    // Scores this cycle's handshakes, then advances to the next falling edge.
    task automatic post();
        logic [15:0] e;
        if (first_valid < 0 && valid) first_valid = cyc;
        if (redirect) begin
            chk("req_on_redirect", {15'h0000, req}, 16'h0000);
            exp_q.delete();
            model_pc = {redirect_pc[15:1], 1'b0};
        end else begin
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {15'h0000, valid}, 16'h0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e);
                    chk("instr", instr, mem_word(e));
                end
            end
            if (req && gnt) begin
                chk("imem_addr", addr, model_pc);
                exp_q.push_back(model_pc);
                pend_addr.push_back(addr);
                pend_due.push_back(cyc + lat);
                model_pc = model_pc + 16'h0002;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        cycle();
        redirect    = 1'b0;
    endtask

    task automatic drain();
        gnt   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && pend_addr.size() == 0) break;
            cycle();
        end
        chk("drain_expected", 16'(exp_q.size()), 16'h0000);
        chk("drain_inflight", 16'(pend_addr.size()), 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; gnt = 1'b0;
        rvalid = 1'b0; rdata = 16'h0000; ready = 1'b0; model_pc = 16'h0000;
        @(negedge clk); #1;
        chk("rst_req", {15'h0000, req}, 16'h0000);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_valid", {15'h0000, valid}, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // 1: sequential stream from RESET_PC
        gnt = 1'b1; ready = 1'b1; lat = 1;
        pre();
        chk("boot_no_req", {15'h0000, req}, 16'h0000);
        post();
        repeat (20) cycle();
        chk("first_valid_cycle", 16'(first_valid), 16'd3);
`ifdef Z16_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 16'(rv_cnt));
`endif

        // 2: decoder stalls, buffer fills to depth and fetch stops
        ready = 1'b0;
        repeat (10) cycle();
        pre();
        chk("full_no_req", {15'h0000, req}, 16'h0000);
        chk("full_valid", {15'h0000, valid}, 16'h0001);
        chk("full_buffered", 16'(exp_q.size()), 16'd2);
        chk("full_inflight", 16'(pend_addr.size()), 16'h0000);
        post();
        ready   = 1'b1;
        snap_pc = model_pc;
        repeat (10) cycle();
        chk("fetch_resumed", {15'h0000, model_pc != snap_pc}, 16'h0001);
        drain();

        // 3: redirect with two reads in flight
        lat = 3; gnt = 1'b1; ready = 1'b1;
        redirect_to(16'h0010);
        cycle();
        cycle();
        pre();
        chk("t3_inflight", 16'(pend_addr.size()), 16'd2);
        if (pend_addr.size() == 2) begin
            chk("t3_inflight0", pend_addr[0], 16'h0010);
            chk("t3_inflight1", pend_addr[1], 16'h0012);
        end
        redirect = 1'b1; redirect_pc = 16'h0101;
        #1;
        post();
        redirect = 1'b0; lat = 1;
        pre();
        chk("t3_discard", 16'(dut.discard_q), 16'd2);
        chk("t3_no_valid", {15'h0000, valid}, 16'h0000);
        post();
        repeat (12) cycle();
        drain();

        // 4: grant withheld, request and address hold
        redirect_to(16'h0040);
        for (int i = 0; i < 5; i++) begin
            pre();
            chk("t4_req_hold", {15'h0000, req}, 16'h0001);
            chk("t4_addr_hold", addr, 16'h0040);
            post();
        end
        gnt = 1'b1;
        cycle();
        gnt = 1'b0;
        pre();
        chk("t4_req_next", {15'h0000, req}, 16'h0001);
        chk("t4_addr_next", addr, 16'h0042);
        post();
        drain();

        // 5: wrap past 0xFFFE, then redirect coincident with rvalid and pop
        lat = 1; gnt = 1'b1; ready = 1'b1;
        redirect_to(16'hFFFF);
        found = 0; exp_disc = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            pre();
            if (rvalid && valid) begin
                redirect = 1'b1; redirect_pc = 16'h0200;
                #1;
                exp_disc = pend_addr.size();
                found = 1;
            end
            post();
            redirect = 1'b0;
        end
        chk("t5_coincident", 16'(found), 16'd1);
        pre();
        chk("t5_no_valid", {15'h0000, valid}, 16'h0000);
        chk("t5_discard", 16'(dut.discard_q), 16'(exp_disc));
        post();
        repeat (10) cycle();
        drain();

        // 6: asynchronous reset with two reads outstanding
        lat = 3; gnt = 1'b1; ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            pre();
            if (pend_addr.size() == 2) found = 1;
            else post();
        end
        chk("t6_two_inflight", 16'(found), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", {15'h0000, req}, 16'h0000);
        chk("t6_rst_addr", addr, 16'h0000);
        chk("t6_rst_valid", {15'h0000, valid}, 16'h0000);
        chk("t6_rst_instr", instr, 16'h0000);
        chk("t6_rst_instr_pc", instr_pc, 16'h0000);
`ifdef Z16_FETCH_PERF_EN
        chk("t6_perf_fetched_rst", perf_fetched, 16'h0000);
        chk("t6_perf_bubble_rst", perf_bubble, 16'h0000);
`endif
        exp_q.delete(); pend_addr.delete(); pend_due.delete();
        rvalid = 1'b0; rdata = 16'h0000; model_pc = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; cyc = 0; first_valid = -1; lat = 1;
        repeat (12) cycle();
        chk("t6_first_valid_cycle", 16'(first_valid), 16'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
